// File: rtl/axi4lite_if.sv
// AXI4-Lite channel bundle shared by the arbiter's upstream and downstream ports.
// Only the handshake, address, data and response fields are carried.
`timescale 1ns/1ps
interface axi4lite_if #(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 32
);
    logic                      AW_VALID;
    logic                      AW_READY;
    logic [AXI_ADDR_WIDTH-1:0] AW_ADDR;
    logic                      W_VALID;
    logic                      W_READY;
    logic [AXI_DATA_WIDTH-1:0] W_DATA;
    logic                      B_VALID;
    logic                      B_READY;
    logic [1:0]                B_RESP;
    logic                      AR_VALID;
    logic                      AR_READY;
    logic [AXI_ADDR_WIDTH-1:0] AR_ADDR;
    logic                      R_VALID;
    logic                      R_READY;
    logic [AXI_DATA_WIDTH-1:0] R_DATA;
    logic [1:0]                R_RESP;

    modport master (
        output AW_VALID, AW_ADDR, W_VALID, W_DATA, B_READY, AR_VALID, AR_ADDR, R_READY,
        input  AW_READY, W_READY, B_VALID, B_RESP, AR_READY, R_VALID, R_DATA, R_RESP
    );

    modport slave (
        input  AW_VALID, AW_ADDR, W_VALID, W_DATA, B_READY, AR_VALID, AR_ADDR, R_READY,
        output AW_READY, W_READY, B_VALID, B_RESP, AR_READY, R_VALID, R_DATA, R_RESP
    );
endinterface

// File: rtl/axi4lite_arbiter_2x1.sv
// Two-master to one-slave AXI4-Lite arbiter: round-robin, one transaction in flight,
// channels forwarded combinationally between the granted master and the slave.
`timescale 1ns/1ps
module axi4lite_arbiter_2x1 #(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 32
) (
    input  logic       A_CLK,
    input  logic       A_RSTn,
    axi4lite_if.slave  m0,
    axi4lite_if.slave  m1,
    axi4lite_if.master s
);

    typedef enum logic [2:0] {
        StIdle,
        StWr,
        StWrResp,
        StRd,
        StRdData
    } state_e;

    state_e state_q, state_d;
    logic   gnt_q, gnt_d;
    logic   last_q, last_d;
    logic   aw_done_q, aw_done_d;
    logic   w_done_q, w_done_d;
    logic   pick;

    // Request-side signals of the granted master
    logic                      g_aw_valid, g_w_valid, g_b_ready, g_ar_valid, g_r_ready;
    logic [AXI_ADDR_WIDTH-1:0] g_aw_addr, g_ar_addr;
    logic [AXI_DATA_WIDTH-1:0] g_w_data;

    // Response-side signals headed to the granted master
    logic                      u_aw_ready, u_w_ready, u_b_valid, u_ar_ready, u_r_valid;
    logic [1:0]                u_b_resp, u_r_resp;
    logic [AXI_DATA_WIDTH-1:0] u_r_data;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

    assign g_aw_valid = gnt_q ? m1.AW_VALID : m0.AW_VALID;
    assign g_aw_addr  = gnt_q ? m1.AW_ADDR  : m0.AW_ADDR;
    assign g_w_valid  = gnt_q ? m1.W_VALID  : m0.W_VALID;
    assign g_w_data   = gnt_q ? m1.W_DATA   : m0.W_DATA;
    assign g_b_ready  = gnt_q ? m1.B_READY  : m0.B_READY;
    assign g_ar_valid = gnt_q ? m1.AR_VALID : m0.AR_VALID;
    assign g_ar_addr  = gnt_q ? m1.AR_ADDR  : m0.AR_ADDR;
    assign g_r_ready  = gnt_q ? m1.R_READY  : m0.R_READY;

    always_comb begin
        s.AW_VALID = 1'b0;
        s.AW_ADDR  = '0;
        s.W_VALID  = 1'b0;
        s.W_DATA   = '0;
        s.B_READY  = 1'b0;
        s.AR_VALID = 1'b0;
        s.AR_ADDR  = '0;
        s.R_READY  = 1'b0;
        u_aw_ready = 1'b0;
        u_w_ready  = 1'b0;
        u_b_valid  = 1'b0;
        u_b_resp   = 2'b00;
        u_ar_ready = 1'b0;
        u_r_valid  = 1'b0;
        u_r_data   = '0;
        u_r_resp   = 2'b00;
        unique case (state_q)
            StWr: begin
                // Done flags mask a channel once its handshake has happened
                s.AW_VALID = g_aw_valid & ~aw_done_q;
                s.AW_ADDR  = g_aw_addr;
                u_aw_ready = s.AW_READY & ~aw_done_q;
                s.W_VALID  = g_w_valid & ~w_done_q;
                s.W_DATA   = g_w_data;
                u_w_ready  = s.W_READY & ~w_done_q;
            end
            StWrResp: begin
                s.B_READY = g_b_ready;
                u_b_valid = s.B_VALID;
                u_b_resp  = s.B_RESP;
            end
            StRd: begin
                s.AR_VALID = g_ar_valid;
                s.AR_ADDR  = g_ar_addr;
                u_ar_ready = s.AR_READY;
            end
            StRdData: begin
                s.R_READY = g_r_ready;
                u_r_valid = s.R_VALID;
                u_r_data  = s.R_DATA;
                u_r_resp  = s.R_RESP;
            end
            default: ;
        endcase
    end

    assign m0.AW_READY = ~gnt_q & u_aw_ready;
    assign m0.W_READY  = ~gnt_q & u_w_ready;
    assign m0.B_VALID  = ~gnt_q & u_b_valid;
    assign m0.B_RESP   = gnt_q ? 2'b00 : u_b_resp;
    assign m0.AR_READY = ~gnt_q & u_ar_ready;
    assign m0.R_VALID  = ~gnt_q & u_r_valid;
    assign m0.R_DATA   = gnt_q ? '0 : u_r_data;
    assign m0.R_RESP   = gnt_q ? 2'b00 : u_r_resp;

    assign m1.AW_READY = gnt_q & u_aw_ready;
    assign m1.W_READY  = gnt_q & u_w_ready;
    assign m1.B_VALID  = gnt_q & u_b_valid;
    assign m1.B_RESP   = gnt_q ? u_b_resp : 2'b00;
    assign m1.AR_READY = gnt_q & u_ar_ready;
    assign m1.R_VALID  = gnt_q & u_r_valid;
    assign m1.R_DATA   = gnt_q ? u_r_data : '0;
    assign m1.R_RESP   = gnt_q ? u_r_resp : 2'b00;

    assign aw_hs = s.AW_VALID & s.AW_READY;
    assign w_hs  = s.W_VALID & s.W_READY;
    assign b_hs  = s.B_VALID & s.B_READY;
    assign ar_hs = s.AR_VALID & s.AR_READY;
    assign r_hs  = s.R_VALID & s.R_READY;

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        last_d    = last_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        pick      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (m0.AW_VALID | m0.AR_VALID | m1.AW_VALID | m1.AR_VALID) begin
                    if ((m0.AW_VALID | m0.AR_VALID) && (m1.AW_VALID | m1.AR_VALID)) begin
                        pick = ~last_q;
                    end else begin
                        pick = m1.AW_VALID | m1.AR_VALID;
                    end
                    gnt_d   = pick;
                    // A write is served ahead of a simultaneous read from the same master
                    state_d = (pick ? m1.AW_VALID : m0.AW_VALID) ? StWr : StRd;
                end
            end
            StWr: begin
                aw_done_d = aw_done_q | aw_hs;
                w_done_d  = w_done_q | w_hs;
                if (aw_done_d && w_done_d) begin
                    state_d   = StWrResp;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            StWrResp: begin
                if (b_hs) begin
                    last_d  = gnt_q;
                    state_d = StIdle;
                end
            end
            StRd: begin
                if (ar_hs) begin
                    state_d = StRdData;
                end
            end
            StRdData: begin
                if (r_hs) begin
                    last_d  = gnt_q;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge A_CLK or negedge A_RSTn) begin
        if (!A_RSTn) begin
            state_q   <= StIdle;
            gnt_q     <= 1'b0;
            last_q    <= 1'b1;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            last_q    <= last_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

endmodule
